schoolbook_radix: RTL and testbench
===================================

SCHOOLBOOK_RADIX -- requirements
Module: schoolbook_radix

Interface
REQ-001 SHALL have parameter AW, default 256, width of operand a.
REQ-002 SHALL have parameter BW, default 256, width of operand b.
REQ-003 SHALL have parameter DW, default 2, bits of b consumed per cycle (digit width, 1..BW); NDIG = ceil(BW/DW).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port a  input  AW  multiplicand, unsigned; captured on accepted start.
REQ-008 SHALL have port b  input  BW  multiplier, unsigned; captured on accepted start.
REQ-009 SHALL have port busy  output  1  high while in RUN or DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking new valid c.
REQ-011 SHALL have port c  output  AW+BW  product register.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE per REQ-016/REQ-024; DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL, on the edge accepting start (cycle T), register a and b (b zero-extended to NDIG*DW bits), clear accumulator, clear digit counter, enter RUN.
REQ-014 SHALL, in each RUN cycle k (k=0..NDIG-1), add a*b[k*DW +: DW] shifted left by k*DW into an AW+BW-bit accumulator; no carry out of AW+BW bits can occur.
REQ-015 SHALL use a digit counter of ceil(log2(NDIG+1)) bits; it never wraps within one operation.
REQ-016 SHALL, without the configuration macro, leave RUN after digit NDIG-1; done=1 and c=a*b in cycle T+NDIG+1.
REQ-017 SHALL load c from accumulator on the same edge that asserts done; c holds value until next done or reset.
REQ-018 SHALL ignore start while busy=1; captured operands and progress unaffected.
REQ-019 SHALL accept start sampled in the cycle after done (IDLE) -> back-to-back throughput one product per NDIG+2 cycles.
REQ-020 SHALL produce c=0 for a=0 or b=0 with identical latency (absent macro).
REQ-021 SHALL keep done=0 in all cycles other than the DONE state.

Reset
REQ-022 SHALL, while rst=1 at an edge, force state IDLE, c=0, done=0, busy=0, accumulator=0, counter=0; rst dominates start.
REQ-023 SHALL abort an in-progress operation on rst with no done pulse; first start after rst deasserts behaves as from power-up.

Configuration
REQ-024 SHALL, when SCHOOLBOOK_SKIP_ZERO_EN is defined, leave RUN after processing digit k if all b digits above k are zero (or k=NDIG-1); done at T+max(m,1)+1 where m = index of highest nonzero digit +1 (m=0 for b=0).
REQ-025 SHALL, when SCHOOLBOOK_SKIP_ZERO_EN is undefined, have fixed latency per REQ-016 and no zero-detect logic; c values identical in both builds.

Verification
REQ-026 SHALL cover: AW=BW=8, DW=2, a=0xFF, b=0xFF, start at T -> c=0xFE01, done pulse only at T+5, busy high T+1..T+5.
REQ-027 SHALL cover: defaults, a=b=2^256-1 -> c=2^512-2^257+1, done at T+129.
REQ-028 SHALL cover: AW=8, BW=7, DW=3 (NDIG=3), a=0xAB, b=0x7F -> c=0x54D5, done at T+4.
REQ-029 SHALL cover: start pulsed with a=3,b=5 during busy of a=7,b=9 run -> single done with c=63; no second done.
REQ-030 SHALL cover: rst=1 at T+3 of a running operation -> c=0, done never asserted, busy=0 next cycle; following start a=2,b=3 -> c=6.
REQ-031 SHALL cover (macro defined, defaults): b=1, a=5 -> c=5, done at T+2; b=0 -> c=0, done at T+2; b=2^255 -> done at T+129.

Source files
------------

// File: rtl/schoolbook_radix.sv
// Radix-2^DW schoolbook multiplier: one DW-bit digit of b per cycle, c = a*b. Latency NDIG+1 after start
// (SCHOOLBOOK_SKIP_ZERO_EN: stop after highest nonzero digit). start ignored while busy.
module schoolbook_radix #(
  parameter int AW = 256,
  parameter int BW = 256,
  parameter int DW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic             busy,
  output logic             done,
  output logic [AW+BW-1:0] c
);
  localparam int NDIG = (BW + DW - 1) / DW;
  localparam int BPW  = NDIG * DW;
  localparam int PW   = AW + BW;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   a_sh_q, a_sh_d;
  logic [BPW-1:0]  b_sh_q, b_sh_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   c_q, c_d;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   acc_sum;
  logic            last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  // a is pre-shifted and b shifted down each cycle, so the digit product needs no variable shifter
  always_comb begin
    partial = '0;
    for (int j = 0; j < DW; j++) begin
      if (b_sh_q[j]) partial = partial + (a_sh_q << j);
    end
    acc_sum = acc_q + partial;
`ifdef SCHOOLBOOK_SKIP_ZERO_EN
    last = (cnt_q == CW'(NDIG - 1)) || ((b_sh_q >> DW) == '0);
`else
    last = (cnt_q == CW'(NDIG - 1));
`endif
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = PW'(a);
          b_sh_d  = BPW'(b);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << DW;
        b_sh_d = b_sh_q >> DW;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          c_d     = acc_sum;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign c    = c_q;

endmodule

// File: tb/tb_schoolbook_radix.sv
// Bench for schoolbook_radix: three parameter sets, scoreboard of expected products checked on done,
// directed latency/busy/abort checks. Expected latency follows SCHOOLBOOK_SKIP_ZERO_EN when defined.
module tb_schoolbook_radix;
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   start_s;
  logic [255:0] a_v, b_v;
  logic [2:0]   busy_s, done_s;
  logic [15:0]  c0;
  logic [511:0] c1;
  logic [14:0]  c2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           idx;
    logic [511:0] c;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  schoolbook_radix #(.AW(8), .BW(8), .DW(2)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .a(a_v[7:0]), .b(b_v[7:0]),
    .busy(busy_s[0]), .done(done_s[0]), .c(c0));
  schoolbook_radix u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .a(a_v), .b(b_v),
    .busy(busy_s[1]), .done(done_s[1]), .c(c1));
  schoolbook_radix #(.AW(8), .BW(7), .DW(3)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .a(a_v[7:0]), .b(b_v[6:0]),
    .busy(busy_s[2]), .done(done_s[2]), .c(c2));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] cval(input int i);
    case (i)
      0:       return {496'b0, c0};
      1:       return c1;
      default: return {497'b0, c2};
    endcase
  endfunction

  function automatic void cfg(input int i, output int aw, output int bw, output int dw);
    case (i)
      0:       begin aw = 8;   bw = 8;   dw = 2; end
      1:       begin aw = 256; bw = 256; dw = 2; end
      default: begin aw = 8;   bw = 7;   dw = 3; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [255:0] bm, input int bw, input int dw);
    int ndig;
    int m;
    ndig = (bw + dw - 1) / dw;
    m = 0;
`ifdef SCHOOLBOOK_SKIP_ZERO_EN
    for (int i = 0; i < 256; i++) if (bm[i]) m = i / dw + 1;
    return ((m < 1) ? 1 : m) + 1;
`else
    m = ndig + 1;
    if (bm === 'x) m = 0;
    return m;
`endif
  endfunction

  function automatic logic [511:0] model(input int i, input logic [255:0] av, input logic [255:0] bv,
                                         output logic [255:0] bm);
    int aw, bw, dw;
    logic [255:0] ones;
    logic [511:0] am, bx;
    cfg(i, aw, bw, dw);
    ones = '1;
    am = {256'b0, av & (ones >> (256 - aw))};
    bm = bv & (ones >> (256 - bw));
    bx = {256'b0, bm};
    return am * bx;
  endfunction

  // scoreboard: every done must match the oldest pending expectation
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_s[i] === 1'b1) begin
        if (sb.size() == 0) chk("spurious_done", {511'b0, done_s[i]}, 512'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_unit", i, e.idx);
          chk("product", cval(i), e.c);
        end
      end
    end
  end

  task automatic run(input int idx, input logic [255:0] av, input logic [255:0] bv);
    int aw, bw, dw, lat, n, busy_low;
    logic [255:0] bm;
    exp_t e;
    cfg(idx, aw, bw, dw);
    e.idx = idx;
    e.c = model(idx, av, bv, bm);
    lat = exp_lat(bm, bw, dw);
    sb.push_back(e);
    a_v = av;
    b_v = bv;
    start_s[idx] = 1'b1;
    @(posedge clk); #1;
    start_s[idx] = 1'b0;
    n = 1;
    busy_low = 0;
    while (done_s[idx] !== 1'b1 && n < 400) begin
      if (busy_s[idx] !== 1'b1) busy_low++;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    chk("busy_during_run", busy_low, 0);
    chk("busy_at_done", {511'b0, busy_s[idx]}, 512'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {511'b0, done_s[idx]}, 512'd0);
    chk("idle_after_done", {511'b0, busy_s[idx]}, 512'd0);
  endtask

  initial begin
    int n, dones, first;
    logic [255:0] all1, bm;
    logic [511:0] spec_sq;
    rst = 1'b1;
    start_s = '0;
    a_v = '0;
    b_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {509'b0, busy_s}, 512'd0);
    chk("rst_done", {509'b0, done_s}, 512'd0);
    chk("rst_c0", cval(0), 512'd0);
    chk("rst_c1", cval(1), 512'd0);
    chk("rst_c2", cval(2), 512'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 256'hFF, 256'hFF);
    chk("ff_sq", cval(0), 512'hFE01);
    all1 = '1;
    run(1, all1, all1);
    spec_sq = (512'd1 << 512) - (512'd1 << 257) + 512'd1;
    chk("max_sq", cval(1), spec_sq);
    run(2, 256'hAB, 256'h7F);
    chk("ab_7f", cval(2), 512'h54D5);

    // back-to-back, including zero operands
    run(0, 256'h00, 256'h37);
    run(0, 256'h5A, 256'h00);
    run(0, 256'hC3, 256'h81);
    run(2, 256'hFF, 256'h40);
    run(1, 256'd5, 256'd1);
    run(1, 256'd7, 256'd0);
    run(1, 256'd3, 256'd1 << 255);

    // start during busy is ignored
    begin
      exp_t e;
      e.idx = 0;
      e.c = model(0, 256'd7, 256'd9, bm);
      sb.push_back(e);
    end
    a_v = 256'd7; b_v = 256'd9; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    a_v = 256'd3; b_v = 256'd5; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    n = 3; dones = 0; first = -1;
    for (int k = 0; k < 15; k++) begin
      if (done_s[0] === 1'b1) begin
        dones++;
        if (first < 0) first = n;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("busy_start_dones", dones, 1);
    chk("busy_start_lat", first, exp_lat(256'd9, 8, 2));
    chk("busy_start_c", cval(0), 512'd63);

    // reset aborts a running operation
    a_v = 256'h55; b_v = 256'h77; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {511'b0, busy_s[0]}, 512'd0);
    chk("abort_c", cval(0), 512'd0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (done_s[0] === 1'b1) dones++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", dones, 0);
    run(0, 256'd2, 256'd3);
    chk("after_abort", cval(0), 512'd6);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
